// File: rtl/nn_pkg.sv
// nn_pkg -- shared constants and helpers for the small CNN datapath.
//   DATA_W      : default pixel width per channel
//   CONV_OUT_W/H: feature-map dimensions produced by the conv/ReLU stages
//   NUM_CH      : number of channels carried through the pipeline
//   px_max      : max of two MAX_W-bit operands. Callers extend their pixels
//                 to MAX_W first (sign- or zero-extension to match the mode).
// Optional feature macro: MAXPOOL2X2_SIGNED_EN (signed two's-complement max).
package nn_pkg;

  localparam int DATA_W     = 8;
  localparam int CONV_OUT_W = 6;
  localparam int CONV_OUT_H = 6;
  localparam int NUM_CH     = 2;

  // Comparison width; wide enough for any realistic pixel width.
  localparam int MAX_W      = 32;

  function automatic logic [MAX_W-1:0] px_max(input logic [MAX_W-1:0] a,
                                              input logic [MAX_W-1:0] b);
`ifdef MAXPOOL2X2_SIGNED_EN
    return ($signed(a) >= $signed(b)) ? a : b;
`else
    return (a >= b) ? a : b;
`endif
  endfunction

endpackage

// File: rtl/maxpool2x2_stream_pool_channel.sv
// pool_channel -- one channel of the 2x2 stride-2 max-pool.
// Holds the running temp register, a half-row line buffer (IMG_W/2 entries)
// and the registered pooled output. The parent supplies the position decode.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   pix_valid   : pixel qualifier
//   pix         : incoming pixel
//   row_odd     : current pixel is on an odd row
//   col_odd     : current pixel is on an odd column
//   buf_idx     : line-buffer slot (col >> 1)
//   out_data    : pooled pixel, holds between updates
// Optional feature macro: MAXPOOL2X2_SIGNED_EN (signed comparison).
module pool_channel
  import nn_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 6,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix,
  input  logic              row_odd,
  input  logic              col_odd,
  input  logic [IDX_W-1:0]  buf_idx,
  output logic [DATA_W-1:0] out_data
);

  localparam int LB_DEPTH = IMG_W / 2;

  logic [DATA_W-1:0] temp_q, temp_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] line_buf_q [LB_DEPTH];
  logic              lb_we_s;
  logic [DATA_W-1:0] lb_wdata_s;

  // Extend a pixel to the comparison width matching the numeric mode.
  function automatic logic [MAX_W-1:0] px_ext(input logic [DATA_W-1:0] v);
`ifdef MAXPOOL2X2_SIGNED_EN
    return MAX_W'(signed'(v));
`else
    return MAX_W'(v);
`endif
  endfunction

  function automatic logic [DATA_W-1:0] max_px(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [MAX_W-1:0] w;
    w = px_max(px_ext(a), px_ext(b));
    return w[DATA_W-1:0];
  endfunction

  // Next-state for temp, line-buffer write and output, keyed by window position.
  always_comb begin
    temp_d     = temp_q;
    out_d      = out_q;
    lb_we_s    = 1'b0;
    lb_wdata_s = '0;
    if (pix_valid) begin
      case ({row_odd, col_odd})
        2'b00: temp_d = pix;
        2'b01: begin
          // Top-row pair max parked until the bottom row arrives.
          lb_we_s    = 1'b1;
          lb_wdata_s = max_px(temp_q, pix);
        end
        2'b10: temp_d = max_px(line_buf_q[buf_idx], pix);
        2'b11: out_d  = max_px(temp_q, pix);
        default: temp_d = temp_q;
      endcase
    end else begin
      temp_d = temp_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      temp_q <= '0;
      out_q  <= '0;
      for (int i = 0; i < LB_DEPTH; i++) begin
        line_buf_q[i] <= '0;
      end
    end else begin
      temp_q <= temp_d;
      out_q  <= out_d;
      if (lb_we_s) begin
        line_buf_q[buf_idx] <= lb_wdata_s;
      end
    end
  end

  assign out_data = out_q;

endmodule

// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream -- two-channel 2x2 stride-2 max-pool on a raster stream.
// Input : IMG_W x IMG_H pixels per channel, one per input_valid pulse.
// Output: (IMG_W/2) x (IMG_H/2) pooled pixels per channel in raster order,
//         one output_valid pulse each, output_last on the final one.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   input_data_0/1, input_valid   : pixel stream (no backpressure)
//   output_data_0/1               : pooled pixels, hold between pulses
//   output_valid, output_last     : one-cycle pulse / end-of-frame marker
// Optional feature macro: MAXPOOL2X2_SIGNED_EN (signed max comparison).
module maxpool2x2_stream
  import nn_pkg::*;
#(
  parameter int DATA_W = nn_pkg::DATA_W,
  parameter int IMG_W  = nn_pkg::CONV_OUT_W,
  parameter int IMG_H  = nn_pkg::CONV_OUT_H
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] input_data_0,
  input  logic [DATA_W-1:0] input_data_1,
  input  logic              input_valid,
  output logic [DATA_W-1:0] output_data_0,
  output logic [DATA_W-1:0] output_data_1,
  output logic              output_valid,
  output logic              output_last
);

  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int IDX_W = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;

  if ((IMG_W % 2) != 0) begin : g_img_w_odd
    $error("maxpool2x2_stream: IMG_W must be even");
  end
  if ((IMG_H % 2) != 0) begin : g_img_h_odd
    $error("maxpool2x2_stream: IMG_H must be even");
  end

  logic [CW-1:0]    col_cnt_q, col_cnt_d;
  logic [RW-1:0]    row_cnt_q, row_cnt_d;
  logic             output_valid_q, output_valid_d;
  logic             output_last_q, output_last_d;
  logic             col_last_s, row_last_s;
  logic             row_odd_s, col_odd_s;
  logic [IDX_W-1:0] buf_idx_s;

  // Shared position decode for both channels.
  assign col_last_s = (col_cnt_q == CW'(IMG_W - 1));
  assign row_last_s = (row_cnt_q == RW'(IMG_H - 1));
  assign row_odd_s  = row_cnt_q[0];
  assign col_odd_s  = col_cnt_q[0];
  assign buf_idx_s  = IDX_W'(col_cnt_q >> 1);

  // Raster counters and output qualifiers; frame wrap has no idle gap.
  always_comb begin
    col_cnt_d      = col_cnt_q;
    row_cnt_d      = row_cnt_q;
    output_valid_d = 1'b0;
    output_last_d  = 1'b0;
    if (input_valid) begin
      if (col_last_s) begin
        col_cnt_d = '0;
        if (row_last_s) begin
          row_cnt_d = '0;
        end else begin
          row_cnt_d = row_cnt_q + 1'b1;
        end
      end else begin
        col_cnt_d = col_cnt_q + 1'b1;
        row_cnt_d = row_cnt_q;
      end
      // Bottom-right pixel of a window completes one pooled pixel.
      output_valid_d = row_odd_s & col_odd_s;
      output_last_d  = row_odd_s & col_odd_s & row_last_s & col_last_s;
    end else begin
      output_valid_d = 1'b0;
      output_last_d  = 1'b0;
    end
  end

  // Counter and output-qualifier registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_cnt_q      <= '0;
      row_cnt_q      <= '0;
      output_valid_q <= 1'b0;
      output_last_q  <= 1'b0;
    end else begin
      col_cnt_q      <= col_cnt_d;
      row_cnt_q      <= row_cnt_d;
      output_valid_q <= output_valid_d;
      output_last_q  <= output_last_d;
    end
  end

  assign output_valid = output_valid_q;
  assign output_last  = output_last_q;

  pool_channel #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W),
    .IDX_W  (IDX_W)
  ) u_ch0 (
    .clk       (clk),
    .reset     (reset),
    .pix_valid (input_valid),
    .pix       (input_data_0),
    .row_odd   (row_odd_s),
    .col_odd   (col_odd_s),
    .buf_idx   (buf_idx_s),
    .out_data  (output_data_0)
  );

  pool_channel #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W),
    .IDX_W  (IDX_W)
  ) u_ch1 (
    .clk       (clk),
    .reset     (reset),
    .pix_valid (input_valid),
    .pix       (input_data_1),
    .row_odd   (row_odd_s),
    .col_odd   (col_odd_s),
    .buf_idx   (buf_idx_s),
    .out_data  (output_data_1)
  );

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Self-checking bench for maxpool2x2_stream (6x6 frames, 8-bit pixels).
// Expected pooled values come from a whole-window reference (max of the four
// frame pixels of each window) or from constant tables; pulses are expected
// exactly one step after the bottom-right pixel of each window is driven.
module tb_maxpool2x2_stream;

  localparam int DW    = 8;
  localparam int W     = 6;
  localparam int H     = 6;
  localparam int PW    = W / 2;
  localparam int NPOOL = (W / 2) * (H / 2);

  logic          clk;
  logic          reset;
  logic [DW-1:0] input_data_0, input_data_1;
  logic          input_valid;
  logic [DW-1:0] output_data_0, output_data_1;
  logic          output_valid, output_last;

  maxpool2x2_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk           (clk),
    .reset         (reset),
    .input_data_0  (input_data_0),
    .input_data_1  (input_data_1),
    .input_valid   (input_valid),
    .output_data_0 (output_data_0),
    .output_data_1 (output_data_1),
    .output_valid  (output_valid),
    .output_last   (output_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] p00, p01, p10, p11;
    logic [DW-1:0] exp;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d0, d1;
    logic          last;
    int            cyc;
  } exp_t;

  vec_t          tbl [6];
  exp_t          exp_q [$];
  logic [DW-1:0] f0 [H][W];
  logic [DW-1:0] f1 [H][W];
  logic [DW-1:0] ovr [NPOOL];
  logic [DW-1:0] ramp_exp [NPOOL];
  logic [DW-1:0] hold0, hold1;
  logic          prev_rst;
  int            n_cmp, n_err, step_cnt, n_pulse;

  function automatic logic [DW-1:0] sel(input logic [DW-1:0] u, input logic [DW-1:0] s);
`ifdef MAXPOOL2X2_SIGNED_EN
    return s;
`else
    return u;
`endif
  endfunction

  function automatic logic [DW-1:0] mx(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef MAXPOOL2X2_SIGNED_EN
    return ($signed(a) > $signed(b)) ? a : b;
`else
    return (a > b) ? a : b;
`endif
  endfunction

  function automatic logic [DW-1:0] mx4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                        input logic [DW-1:0] c, input logic [DW-1:0] d);
    return mx(mx(a, b), mx(c, d));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (step %0d)", nm, act, req, step_cnt);
    end
  endtask

  // Check the outputs visible during the current step.
  task automatic observe();
    exp_t e;
    if (prev_rst) begin
      chk("rst_valid", output_valid, 0);
      chk("rst_last", output_last, 0);
      chk("rst_data0", output_data_0, 0);
      chk("rst_data1", output_data_1, 0);
      hold0 = '0;
      hold1 = '0;
    end else if (output_valid) begin
      n_pulse++;
      if (exp_q.size() == 0) begin
        chk("spurious_valid", output_valid, 0);
      end else begin
        e = exp_q.pop_front();
        chk("data0", output_data_0, e.d0);
        chk("data1", output_data_1, e.d1);
        chk("last", output_last, e.last);
        chk("latency", step_cnt, e.cyc);
        hold0 = e.d0;
        hold1 = e.d1;
      end
    end else begin
      chk("idle_last", output_last, 0);
      chk("hold_data0", output_data_0, hold0);
      chk("hold_data1", output_data_1, hold1);
    end
  endtask

  // One clock: drive just after the rising edge, observe at the falling edge.
  task automatic step(input logic v, input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                      input logic rst);
    @(posedge clk);
    #1;
    input_valid  = v;
    input_data_0 = a0;
    input_data_1 = a1;
    reset        = rst;
    @(negedge clk);
    observe();
    prev_rst = rst;
    step_cnt++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, DW'($urandom), DW'($urandom), 1'b0);
  endtask

  // gap_mode: >=0 fixed idle steps after each pixel, <0 random 0..2.
  task automatic drive_frame(input int gap_mode, input bit use_ovr, input int npix);
    int r, c, g;
    exp_t e;
    for (int i = 0; i < npix; i++) begin
      r = i / W;
      c = i % W;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        e.d0   = use_ovr ? ovr[(r / 2) * PW + (c / 2)]
                         : mx4(f0[r-1][c-1], f0[r-1][c], f0[r][c-1], f0[r][c]);
        e.d1   = mx4(f1[r-1][c-1], f1[r-1][c], f1[r][c-1], f1[r][c]);
        e.last = (r == H - 1) && (c == W - 1);
        e.cyc  = step_cnt + 1;
        exp_q.push_back(e);
      end
      step(1'b1, f0[r][c], f1[r][c], 1'b0);
      g = (gap_mode < 0) ? int'($urandom_range(0, 2)) : gap_mode;
      idle(g);
    end
  endtask

  task automatic drain(input int npulse);
    idle(3);
    chk("exp_queue_empty", exp_q.size(), 0);
    chk("pulse_count", n_pulse, npulse);
    exp_q.delete();
    n_pulse = 0;
  endtask

  task automatic fill_random();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        f0[r][c] = DW'($urandom);
        f1[r][c] = DW'($urandom);
      end
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        f0[r][c] = DW'(r * W + c);
        f1[r][c] = DW'($urandom);
      end
    for (int k = 0; k < NPOOL; k++) ovr[k] = ramp_exp[k];
  endtask

  initial begin
    tbl[0] = '{p00: 8'h80, p01: 8'h7F, p10: 8'hFF, p11: 8'h01, exp: sel(8'hFF, 8'h7F)};
    tbl[1] = '{p00: 8'h00, p01: 8'h00, p10: 8'h00, p11: 8'h00, exp: sel(8'h00, 8'h00)};
    tbl[2] = '{p00: 8'h10, p01: 8'h20, p10: 8'h30, p11: 8'h40, exp: sel(8'h40, 8'h40)};
    tbl[3] = '{p00: 8'hFE, p01: 8'h05, p10: 8'h03, p11: 8'h02, exp: sel(8'hFE, 8'h05)};
    tbl[4] = '{p00: 8'h81, p01: 8'h80, p10: 8'h82, p11: 8'h83, exp: sel(8'h83, 8'h83)};
    tbl[5] = '{p00: 8'h7F, p01: 8'h80, p10: 8'h80, p11: 8'h80, exp: sel(8'h80, 8'h7F)};
    ramp_exp = '{8'd7, 8'd9, 8'd11, 8'd19, 8'd21, 8'd23, 8'd31, 8'd33, 8'd35};

    n_cmp = 0; n_err = 0; step_cnt = 0; n_pulse = 0;
    hold0 = '0; hold1 = '0;
    prev_rst = 1'b1;
    reset = 1'b1; input_valid = 1'b0; input_data_0 = '0; input_data_1 = '0;

    // Reset state.
    repeat (3) step(1'b0, '0, '0, 1'b1);
    idle(2);

    // Table-driven windows: every window of the frame carries the same pattern.
    for (int t = 0; t < 6; t++) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          f0[r][c] = (r % 2 == 0) ? ((c % 2 == 0) ? tbl[t].p00 : tbl[t].p01)
                                  : ((c % 2 == 0) ? tbl[t].p10 : tbl[t].p11);
          f1[r][c] = f0[r][c] ^ 8'h3C;
        end
      for (int k = 0; k < NPOOL; k++) ovr[k] = tbl[t].exp;
      drive_frame(0, 1'b1, W * H);
      drain(NPOOL);
    end

    // Ramp frame, back-to-back valid.
    fill_ramp();
    drive_frame(0, 1'b1, W * H);
    drain(NPOOL);

    // Single hot pixel on channel 1.
    fill_random();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) f1[r][c] = 8'h00;
    f1[2][3] = 8'd200;
    drive_frame(0, 1'b0, W * H);
    drain(NPOOL);

    // Gapped valid: one pixel every third cycle.
    fill_ramp();
    drive_frame(2, 1'b1, W * H);
    drain(NPOOL);

    // Back-to-back frames: ramp then all 0xFF, no gap between them.
    fill_ramp();
    drive_frame(0, 1'b1, W * H);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        f0[r][c] = 8'hFF;
        f1[r][c] = 8'hFF;
      end
    for (int k = 0; k < NPOOL; k++) ovr[k] = 8'hFF;
    drive_frame(0, 1'b1, W * H);
    drain(2 * NPOOL);

    // Reset after 20 pixels, then a full ramp frame.
    fill_random();
    drive_frame(0, 1'b0, 20);
    step(1'b0, DW'($urandom), DW'($urandom), 1'b1);
    step(1'b1, DW'($urandom), DW'($urandom), 1'b1);
    drain(4);
    fill_ramp();
    drive_frame(0, 1'b1, W * H);
    drain(NPOOL);

    // Randomized frames with random gaps, frames abutting.
    for (int f = 0; f < 4; f++) begin
      fill_random();
      drive_frame(-1, 1'b0, W * H);
    end
    drain(4 * NPOOL);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
